// File: rtl/traceback_ptr_encoder.sv
// Forward-fill traceback encoder: turns per-cell affine-gap DP decisions into 5-bit
// codes, packs PACK codes per memory word row by row, and tracks the best local score.
module traceback_ptr_encoder #(
  parameter int PACK    = 4,
  parameter int LEN_W   = 10,
  parameter int ADDR_W  = 16,
  parameter int SCORE_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [LEN_W-1:0]          qlen,
  input  logic [LEN_W-1:0]          rlen,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                in_src,
  input  logic [3:0]                in_ext,
  input  logic signed [SCORE_W-1:0] in_score,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [5*PACK-1:0]         mem_wdata,
  output logic                      busy,
  output logic                      done,
  output logic signed [SCORE_W-1:0] best_score,
  output logic [LEN_W-1:0]          best_row,
  output logic [LEN_W-1:0]          best_col
);

  localparam int SLOT_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PACK - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]        r_state;
  logic [LEN_W-1:0]  r_qlen;
  logic [LEN_W-1:0]  r_rlen;
  logic [LEN_W-1:0]  r_row;
  logic [LEN_W-1:0]  r_col;
  logic [SLOT_W-1:0] r_slot;
  logic [5*PACK-1:0] r_buf;
  logic [ADDR_W-1:0] r_addr;

  logic [4:0]        w_code;
  logic [5*PACK-1:0] w_word;
  logic              w_accept;
  logic              w_lastCol;
  logic              w_lastRow;
  logic              w_wordEnd;

  // Non-M sources end in 01 so that an I decision can never read back as STOP.
  always_comb begin
    w_code = 5'b00000;
    case (in_src)
      3'd0:    w_code = {1'b1, in_ext};
      3'd1:    w_code = 5'b00001;
      3'd2:    w_code = 5'b00101;
      3'd4:    w_code = 5'b01001;
      3'd5:    w_code = 5'b01101;
      default: w_code = 5'b00000;
    endcase
  end

  // Slots above the current one are always zero, so OR-ing in the code also pads the word.
  assign w_word    = r_buf | ((5*PACK)'(w_code) << (5 * r_slot));
  assign in_ready  = (r_state == S_RUN);
  assign busy      = (r_state != S_IDLE);
  assign w_accept  = in_valid && in_ready;
  assign w_lastCol = (r_col == r_qlen - 1'b1);
  assign w_lastRow = (r_row == r_rlen - 1'b1);
  assign w_wordEnd = (r_slot == LAST_SLOT) || w_lastCol;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_qlen     <= '0;
      r_rlen     <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_slot     <= '0;
      r_buf      <= '0;
      r_addr     <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      best_score <= '0;
      best_row   <= '0;
      best_col   <= '0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (qlen != '0 && rlen != '0) begin
              r_qlen     <= qlen;
              r_rlen     <= rlen;
              r_row      <= '0;
              r_col      <= '0;
              r_slot     <= '0;
              r_buf      <= '0;
              r_addr     <= '0;
              mem_addr   <= '0;
              best_score <= '0;
              best_row   <= '0;
              best_col   <= '0;
              r_state    <= S_RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_accept) begin
            if (w_wordEnd) begin
              mem_we    <= 1'b1;
              mem_wdata <= w_word;
              mem_addr  <= r_addr;
              r_addr    <= r_addr + 1'b1;
              r_buf     <= '0;
              r_slot    <= '0;
            end else begin
              r_buf  <= w_word;
              r_slot <= r_slot + 1'b1;
            end
            if (w_lastCol) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
              if (w_lastRow) begin
                done    <= 1'b1;
                r_state <= S_FLUSH;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
            // Strict compare keeps the earliest cell on ties.
            if (in_score > best_score) begin
              best_score <= in_score;
              best_row   <= r_row;
              best_col   <= r_col;
            end
          end
        end
        S_FLUSH: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_traceback_ptr_encoder.sv
// Scoreboard bench for traceback_ptr_encoder: a cell-level reference model queues the
// expected memory writes; a monitor pops and compares them whenever mem_we is seen.
module tb_traceback_ptr_encoder;
  localparam int PACK    = 4;
  localparam int LEN_W   = 10;
  localparam int ADDR_W  = 16;
  localparam int SCORE_W = 16;
  localparam int DW      = 5 * PACK;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      start;
  logic [LEN_W-1:0]          qlen;
  logic [LEN_W-1:0]          rlen;
  logic                      in_valid;
  logic                      in_ready;
  logic [2:0]                in_src;
  logic [3:0]                in_ext;
  logic signed [SCORE_W-1:0] in_score;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DW-1:0]             mem_wdata;
  logic                      busy;
  logic                      done;
  logic signed [SCORE_W-1:0] best_score;
  logic [LEN_W-1:0]          best_row;
  logic [LEN_W-1:0]          best_col;

  traceback_ptr_encoder #(
    .PACK(PACK), .LEN_W(LEN_W), .ADDR_W(ADDR_W), .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .qlen(qlen), .rlen(rlen),
    .in_valid(in_valid), .in_ready(in_ready), .in_src(in_src), .in_ext(in_ext),
    .in_score(in_score), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .best_score(best_score), .best_row(best_row),
    .best_col(best_col)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]                src;
    logic [3:0]                ext;
    logic signed [SCORE_W-1:0] score;
  } cell_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DW-1:0]     data;
    bit                last;
  } wr_t;

  cell_t cellQ[$];
  wr_t   expQ[$];
  wr_t   monE;
  int    compared = 0;
  int    mismatched = 0;
  int    expZeroDone = 0;
  logic [DW-1:0] lastData = '0;
  logic signed [SCORE_W-1:0] expBest;
  int    expRow;
  int    expCol;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Matrix index of the non-M sources I, D, I~, D~ maps to code 4*m+1.
  function automatic logic [4:0] refCode(input logic [2:0] src, input logic [3:0] ext);
    int m;
    case (src)
      3'd0: return {1'b1, ext};
      3'd1: m = 0;
      3'd2: m = 1;
      3'd4: m = 2;
      3'd5: m = 3;
      default: return 5'b00000;
    endcase
    return 5'(4 * m + 1);
  endfunction

  task automatic buildModel(input int q, input int r);
    int words;
    wr_t e;
    words   = (q + PACK - 1) / PACK;
    expBest = '0;
    expRow  = 0;
    expCol  = 0;
    for (int row = 0; row < r; row++) begin
      for (int k = 0; k < words; k++) begin
        e.addr = ADDR_W'(row * words + k);
        e.data = '0;
        e.last = (row == r - 1) && (k == words - 1);
        for (int c = k * PACK; c < q && c < (k + 1) * PACK; c++)
          e.data = e.data | (DW'(refCode(cellQ[row*q+c].src, cellQ[row*q+c].ext)) << (5 * (c - k * PACK)));
        expQ.push_back(e);
      end
      for (int c = 0; c < q; c++) begin
        if (cellQ[row*q+c].score > expBest) begin
          expBest = cellQ[row*q+c].score;
          expRow  = row;
          expCol  = c;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (mem_we === 1'b1) begin
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpectedWrite: got addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
        end else begin
          monE = expQ.pop_front();
          checkOutput("writeAddr", 64'(mem_addr), 64'(monE.addr));
          checkOutput("writeData", 64'(mem_wdata), 64'(monE.data));
          checkOutput("writeDone", 64'(done), 64'(monE.last));
          lastData = mem_wdata;
        end
      end else if (done === 1'b1) begin
        compared++;
        if (expZeroDone > 0) expZeroDone--;
        else begin
          mismatched++;
          $display("[TB] FAIL unexpectedDone: got done=1 without write, expected 0");
        end
      end
    end
  end

  // gapMode: 0 continuous, 1 alternating idle cycles, 2 random idle cycles.
  task automatic applyStimulus(input int q, input int r, input int gapMode, input bit startMid);
    int w;
    buildModel(q, r);
    @(negedge clk);
    start = 1'b1; qlen = LEN_W'(q); rlen = LEN_W'(r);
    @(negedge clk);
    start = 1'b0; qlen = LEN_W'($urandom); rlen = LEN_W'($urandom);
    checkOutput("busyAfterStart", 64'(busy), 64'(1));
    for (int i = 0; i < cellQ.size(); i++) begin
      if ((gapMode == 1 && i % 2 == 1) || (gapMode == 2 && $urandom_range(0, 1) == 1)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_src   = cellQ[i].src;
      in_ext   = cellQ[i].ext;
      in_score = cellQ[i].score;
      if (startMid && i == 1) begin
        start = 1'b1; qlen = 10'd3; rlen = 10'd1;
      end
      w = 0;
      while (in_ready !== 1'b1 && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (w == 20) begin
        checkOutput("inReadyTimeout", 64'(in_ready), 64'(1));
        break;
      end
      @(negedge clk);
      start = 1'b0;
    end
    in_valid = 1'b0;
    w = 0;
    while (done !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    checkOutput("doneSeen", 64'(done), 64'(1));
    @(negedge clk);
    checkOutput("busyAfterDone", 64'(busy), 64'(0));
    checkOutput("donePulseLen", 64'(done), 64'(0));
    checkOutput("pendingWrites", 64'(expQ.size()), 64'(0));
    checkOutput("bestScore", 64'($unsigned(best_score)), 64'($unsigned(expBest)));
    checkOutput("bestRow", 64'(best_row), 64'(expRow));
    checkOutput("bestCol", 64'(best_col), 64'(expCol));
    expQ.delete();
  endtask

  task automatic addCell(input logic [2:0] src, input logic [3:0] ext, input int score);
    cell_t c;
    c.src = src; c.ext = ext; c.score = SCORE_W'(score);
    cellQ.push_back(c);
  endtask

  task automatic randomCells(input int n, input bit fixedSrc, input logic [2:0] src);
    cellQ.delete();
    for (int i = 0; i < n; i++)
      addCell(fixedSrc ? src : 3'($urandom_range(0, 7)), 4'($urandom), int'($urandom_range(0, 30)) - 10);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_memWe"}, 64'(mem_we), 64'(0));
    checkOutput({tag, "_memAddr"}, 64'(mem_addr), 64'(0));
    checkOutput({tag, "_memWdata"}, 64'(mem_wdata), 64'(0));
    checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
    checkOutput({tag, "_done"}, 64'(done), 64'(0));
    checkOutput({tag, "_inReady"}, 64'(in_ready), 64'(0));
    checkOutput({tag, "_bestScore"}, 64'($unsigned(best_score)), 64'(0));
    checkOutput({tag, "_bestRow"}, 64'(best_row), 64'(0));
    checkOutput({tag, "_bestCol"}, 64'(best_col), 64'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; qlen = '0; rlen = '0;
    in_valid = 1'b0; in_src = '0; in_ext = '0; in_score = '0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    cellQ.delete();
    addCell(3'd0, 4'b1010, 2); addCell(3'd1, 4'b1111, 4);
    addCell(3'd2, 4'b0000, 1); addCell(3'd3, 4'b0101, 0);
    applyStimulus(4, 1, 0, 1'b0);
    checkOutput("directWord", 64'(lastData), 64'(20'b00000_00101_00001_11010));

    randomCells(12, 1'b1, 3'd5);
    applyStimulus(6, 2, 0, 1'b0);
    checkOutput("tiltaTailWord", 64'(lastData), 64'(20'b00000_00000_01101_01101));

    cellQ.delete();
    addCell(3'd0, 4'd0, 3); addCell(3'd1, 4'd0, 7); addCell(3'd2, 4'd0, 7);
    addCell(3'd4, 4'd0, -2); addCell(3'd5, 4'd0, 5);
    applyStimulus(5, 1, 0, 1'b0);
    checkOutput("tieScore", 64'($unsigned(best_score)), 64'(7));
    checkOutput("tieCol", 64'(best_col), 64'(1));

    randomCells(8, 1'b0, 3'd0);
    applyStimulus(4, 2, 0, 1'b0);
    applyStimulus(4, 2, 1, 1'b0);

    expZeroDone = 1;
    @(negedge clk);
    start = 1'b1; qlen = 10'd5; rlen = 10'd0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("zeroLenDone", 64'(done), 64'(1));
    checkOutput("zeroLenWe", 64'(mem_we), 64'(0));
    @(negedge clk);
    checkOutput("zeroLenDoneLow", 64'(done), 64'(0));
    checkOutput("zeroLenBusy", 64'(busy), 64'(0));

    randomCells(10, 1'b0, 3'd0);
    applyStimulus(5, 2, 0, 1'b1);

    @(negedge clk);
    start = 1'b1; qlen = 10'd8; rlen = 10'd2;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_src = 3'd0; in_ext = 4'($urandom); in_score = SCORE_W'(10 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkAllZero("midReset");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    randomCells(8, 1'b0, 3'd0);
    applyStimulus(8, 1, 0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      int q;
      int r;
      q = $urandom_range(1, 9);
      r = $urandom_range(1, 4);
      randomCells(q * r, 1'b0, 3'd0);
      applyStimulus(q, r, $urandom_range(0, 2), 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
